// File: rtl/sha256_msg_padder.sv
// Byte-stream to 32-bit word packer with full SHA-256 padding (0x80, zero fill, 64-bit bit length).
// Latency: 1 clk from the completing byte to word_valid. Backpressure: one-entry output register; word_ready low freezes all state and drops in_ready.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] word_data,
    output logic        word_valid,
    output logic        word_last,
    input  logic        word_ready,
    output logic        busy
);

    typedef enum logic [2:0] {DATA, PAD, ZERO, LEN_HI, LEN_LO} state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_idx_q;
    logic [31:0]        word_acc_q;
    logic [LEN_W-1:0]   bit_len_q;
    logic [3:0]         wcnt_q;
    logic [31:0]        word_data_q;
    logic               word_valid_q;
    logic               word_last_q;

    logic               can_load;
    logic               word_acc;
    logic               byte_acc;
    logic [3:0]         slot;
    logic [63:0]        len64;
    logic [31:0]        cur_word;
    logic               load;
    logic [31:0]        load_dat;
    logic               load_last;
    logic               done;

    assign can_load   = !word_valid_q || word_ready;
    assign word_acc   = word_valid_q && word_ready;
    assign byte_acc   = in_valid && in_ready;
    // Block position of a word loaded this cycle: everything loaded earlier is accepted by now.
    assign slot       = wcnt_q + {3'b000, word_acc};
    assign len64      = 64'(bit_len_q);

    assign in_ready   = rst && (state_q == DATA) && can_load;
    assign busy       = (state_q != DATA);
    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign word_last  = word_last_q;

    // Current byte merged into the partial word; a final partial word also gets the marker.
    always_comb begin
        cur_word = word_acc_q;
        case (byte_idx_q)
            2'd0: begin
                cur_word[31:24] = in_byte;
                if (in_last) cur_word[23:16] = 8'h80;
            end
            2'd1: begin
                cur_word[23:16] = in_byte;
                if (in_last) cur_word[15:8] = 8'h80;
            end
            2'd2: begin
                cur_word[15:8] = in_byte;
                if (in_last) cur_word[7:0] = 8'h80;
            end
            default: cur_word[7:0] = in_byte;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DATA;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_dat  = 32'h0;
        load_last = 1'b0;
        done      = 1'b0;
        case (state_q)
            DATA: begin
                if (byte_acc && (in_last || byte_idx_q == 2'd3)) begin
                    load     = 1'b1;
                    load_dat = cur_word;
                end
                if (byte_acc && in_last) begin
                    if (byte_idx_q == 2'd3)  state_d = PAD;
                    else if (slot == 4'd13)  state_d = LEN_HI;
                    else                     state_d = ZERO;
                end
            end
            PAD: begin
                if (can_load) begin
                    load     = 1'b1;
                    load_dat = 32'h8000_0000;
                    state_d  = (slot == 4'd13) ? LEN_HI : ZERO;
                end
            end
            ZERO: begin
                if (can_load) begin
                    load = 1'b1;
                    if (slot == 4'd13) state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (can_load) begin
                    load     = 1'b1;
                    load_dat = len64[63:32];
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (word_valid_q && word_last_q) begin
                    if (word_ready) begin
                        done    = 1'b1;
                        state_d = DATA;
                    end
                end else if (can_load) begin
                    load      = 1'b1;
                    load_dat  = len64[31:0];
                    load_last = 1'b1;
                end
            end
            default: state_d = DATA;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q   <= 2'd0;
            word_acc_q   <= 32'h0;
            bit_len_q    <= '0;
            wcnt_q       <= 4'd0;
            word_data_q  <= 32'h0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
        end else begin
            if (byte_acc) begin
                bit_len_q <= bit_len_q + LEN_W'(8);
                if (in_last || byte_idx_q == 2'd3) begin
                    word_acc_q <= 32'h0;
                    byte_idx_q <= 2'd0;
                end else begin
                    word_acc_q <= cur_word;
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end
            if (done) begin
                bit_len_q  <= '0;
                byte_idx_q <= 2'd0;
                word_acc_q <= 32'h0;
                wcnt_q     <= 4'd0;
            end else if (word_acc) begin
                wcnt_q <= wcnt_q + 4'd1;
            end
            if (load) begin
                word_data_q  <= load_dat;
                word_valid_q <= 1'b1;
                word_last_q  <= load_last;
            end else if (word_acc) begin
                word_valid_q <= 1'b0;
                word_last_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder against a byte-level padding model.
module tb_sha256_msg_padder;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_last;
    logic        word_ready;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          acc_count = 0;
    bit          rdy_mode = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] mq[$];

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .word_data(word_data), .word_valid(word_valid),
        .word_last(word_last), .word_ready(word_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Padded byte image: message, 0x80, zeros to 56 mod 64, big-endian bit count.
    task automatic model(input bq_t msg);
        logic [7:0]  p[$];
        logic [63:0] len;
        p   = msg;
        len = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        mq.delete();
        for (int i = 0; i < p.size(); i += 4)
            mq.push_back({(i + 4 == p.size()), p[i], p[i+1], p[i+2], p[i+3]});
    endtask

    task automatic enqueue();
        foreach (mq[i]) exp_q.push_back(mq[i]);
    endtask

    task automatic mk(input int n, input bit rnd, output bq_t q);
        q = {};
        for (int i = 0; i < n; i++)
            q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(8'h61 + (i % 26)));
    endtask

    task automatic send(input bq_t msg);
        int n;
        for (int i = 0; i < msg.size(); i++) begin
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = (i == msg.size() - 1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 3000);
            if (!in_ready) begin
                check("byte_wait", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            word_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every accepted word, hold stability under backpressure, in_ready during padding.
    initial begin
        logic        hold_vld = 1'b0;
        logic [32:0] hold_dat = '0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_vld = 1'b0;
            end else begin
                if (hold_vld)
                    check("hold", {31'b0, word_valid, word_last, word_data}, {31'b0, 1'b1, hold_dat});
                if (busy) check("in_ready_pad", 64'(in_ready), 64'd0);
                if (word_valid && word_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_word: got %h expected none", {word_last, word_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("word", 64'({word_last, word_data}), 64'(e));
                        acc_count++;
                    end
                end
                hold_vld = word_valid && !word_ready;
                hold_dat = {word_last, word_data};
            end
        end
    end

    initial begin
        bq_t m, m2;
        int  base;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_last",  64'(word_last),  64'd0);
        check("rst_data",  64'(word_data),  64'd0);
        check("rst_busy",  64'(busy),       64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        #3 rst = 1'b1;
        @(posedge clk); #1;

        m = {8'h61, 8'h62, 8'h63};
        model(m);
        check("abc_len", 64'(mq.size()), 64'd16);
        check("abc_w0",  64'(mq[0]),  64'h0_6162_6380);
        check("abc_w15", 64'(mq[15]), 64'h1_0000_0018);
        enqueue(); send(m); drain();

        mk(55, 1'b0, m);
        model(m);
        check("b55_len", 64'(mq.size()), 64'd16);
        check("b55_w13", 64'(mq[13]), 64'h0_6162_6380);
        check("b55_w15", 64'(mq[15]), 64'h1_0000_01B8);
        enqueue(); send(m); drain();

        mk(56, 1'b0, m);
        model(m);
        check("b56_len", 64'(mq.size()), 64'd32);
        check("b56_w14", 64'(mq[14]), 64'h0_8000_0000);
        check("b56_w20", 64'(mq[20]), 64'h0_0000_0000);
        check("b56_w31", 64'(mq[31]), 64'h1_0000_01C0);
        enqueue(); send(m); drain();

        rdy_mode = 1'b1;
        mk(64, 1'b1, m);
        model(m);
        check("b64_len", 64'(mq.size()), 64'd32);
        enqueue(); send(m); drain();

        for (int k = 0; k < 10; k++) begin
            mk($urandom_range(1, 140), 1'b1, m);
            model(m);
            enqueue(); send(m); drain();
        end

        rdy_mode = 1'b0;
        mk(20, 1'b0, m);
        model(m);
        enqueue();
        base = acc_count;
        send(m);
        for (int n = 0; n < 200 && acc_count < base + 5; n++) @(negedge clk);
        check("pre_reset_words", 64'(acc_count - base), 64'd5);
        #3 rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(word_valid), 64'd0);
        check("mid_rst_data",  64'(word_data),  64'd0);
        check("mid_rst_busy",  64'(busy),       64'd0);
        exp_q.delete();
        @(negedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        m = {8'h61, 8'h62, 8'h63};
        model(m);
        enqueue(); send(m); drain();

        m  = {8'h61, 8'h62, 8'h63};
        m2 = {8'h61};
        model(m);
        enqueue();
        model(m2);
        check("a_w0",  64'(mq[0]),  64'h0_6180_0000);
        check("a_w15", 64'(mq[15]), 64'h1_0000_0008);
        enqueue();
        send(m);
        send(m2);
        drain();

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
